// File: rtl/pppc_step_ctrl.sv
// Step/flip sequencer for the ping-pong counter: config latch,
// run/pause FSM, prescaled or single-step enable pulses.
module pppc_step_ctrl #(
  parameter int unsigned DIV = 25000000,
  parameter int unsigned CW  = 25
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] cfg_max_i,
  input  logic [3:0] cfg_min_i,
  input  logic       cfg_load_i,
  input  logic       run_btn_i,
  input  logic       step_req_i,
  input  logic       flip_req_i,
  output logic       cnt_rst_o,
  output logic       cnt_enable_o,
  output logic       cnt_flip_o,
  output logic [3:0] cnt_max_o,
  output logic [3:0] cnt_min_o,
  output logic [1:0] state_o,
  output logic       cfg_err_o,
  output logic       flip_pending_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2,
    PAUSE = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] ps_q, ps_d;
  logic          en_q, en_d;
  logic          flip_q, flip_d;
  logic          pend_q, pend_d;
  logic          rst_q, rst_d;
  logic          err_q, err_d;
  logic [3:0]    max_q, max_d;
  logic [3:0]    min_q, min_d;

  logic cfg_ok;
  logic run_ev;
  logic step_ev;
  logic flip_ev;
  logic tc;

  always_comb begin
    cfg_ok  = cfg_load_i && (cfg_max_i > cfg_min_i);
    run_ev  = run_btn_i && !cfg_load_i;
    step_ev = step_req_i && !cfg_load_i;
    flip_ev = flip_req_i && !cfg_load_i &&
              (state_q == RUN || state_q == PAUSE);
    tc      = (ps_q == CW'(DIV - 1));

    state_d = state_q;
    en_d    = 1'b0;
    flip_d  = 1'b0;
    pend_d  = pend_q;
    err_d   = err_q;
    max_d   = max_q;
    min_d   = min_q;

    unique case (state_q)
      IDLE: ;
      LOAD: state_d = PAUSE;
      RUN: begin
        en_d = tc;
        if (run_ev) state_d = PAUSE;
      end
      PAUSE: begin
        // a step right after a RUN exit pulse would give back-to-back enables
        en_d = step_ev && !en_q;
        if (run_ev) state_d = RUN;
      end
      default: ;
    endcase

    if (en_d) begin
      flip_d = pend_q | flip_ev;
      pend_d = 1'b0;
    end else begin
      pend_d = pend_q | flip_ev;
    end
    if (state_q == LOAD) pend_d = 1'b0;

    if (cfg_ok) begin
      state_d = LOAD;
      max_d   = cfg_max_i;
      min_d   = cfg_min_i;
      err_d   = 1'b0;
      en_d    = 1'b0;
      flip_d  = 1'b0;
      pend_d  = 1'b0;
    end else if (cfg_load_i) begin
      err_d = 1'b1;
    end

    if (state_q == RUN && state_d == RUN)
      ps_d = tc ? '0 : ps_q + CW'(1);
    else
      ps_d = '0;

    rst_d = (state_d == IDLE) || (state_d == LOAD);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ps_q    <= '0;
      en_q    <= 1'b0;
      flip_q  <= 1'b0;
      pend_q  <= 1'b0;
      rst_q   <= 1'b1;
      err_q   <= 1'b0;
      max_q   <= 4'd0;
      min_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      ps_q    <= ps_d;
      en_q    <= en_d;
      flip_q  <= flip_d;
      pend_q  <= pend_d;
      rst_q   <= rst_d;
      err_q   <= err_d;
      max_q   <= max_d;
      min_q   <= min_d;
    end
  end

  assign cnt_rst_o      = rst_q;
  assign cnt_enable_o   = en_q;
  assign cnt_flip_o     = flip_q;
  assign cnt_max_o      = max_q;
  assign cnt_min_o      = min_q;
  assign state_o        = state_q;
  assign cfg_err_o      = err_q;
  assign flip_pending_o = pend_q;

endmodule
